subroutine_ctrl: RTL and testbench
==================================

Name: subroutine_ctrl

Overview:
Sequencing controller in front of the 8-entry subroutine return-address stack. Arbitrates call, return, interrupt-entry and return-from-interrupt requests from the decoder and interrupt line. Drives the stack's one-cycle call/return strobes and tracks stack depth, flagging overflow and underflow. Supplies the PC unit with a load strobe and the next PC.

Parameters:
DEPTH, 8, stack entries; must match the stack instance.
ADDR_W, 12, PC / return-address width.
ISR_ADDR, 12'h004, fixed interrupt vector loaded on interrupt entry.

Ports:
clock  in  1  system clock; all state changes on rising edge.
reset_n  in  1  asynchronous, active-low reset.
call_req  in  1  decoder CALL; level, held until req_ack.
ret_req  in  1  decoder RET; level, held until req_ack.
reti_req  in  1  decoder RETI; level, held until req_ack.
irq  in  1  interrupt request; level.
pc_in  in  ADDR_W  current PC (return address to push).
call_target  in  ADDR_W  CALL destination.
rts_adr  in  ADDR_W  stack top from the stack (registered there).
stack_call  out  1  push strobe to the stack.
stack_return  out  1  pop strobe to the stack.
pc_load  out  1  one-cycle PC load strobe.
pc_next  out  ADDR_W  PC value, valid when pc_load=1.
req_ack  out  1  one-cycle acknowledge of call/ret/reti.
irq_ack  out  1  one-cycle acknowledge of interrupt entry.
busy  out  1  high in any state other than IDLE.
in_isr  out  1  high from interrupt entry to RETI.
depth  out  4  current stack occupancy, 0..DEPTH.
overflow  out  1  sticky: push attempted at depth=DEPTH.
underflow  out  1  sticky: pop attempted at depth=0.

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0, including depth, pc_next, in_isr and both sticky flags.
- States: IDLE, PUSH, POP, SETTLE. All outputs are registered.
- IDLE arbitration, sampled each edge. Priority: irq (only when in_isr=0) > reti_req > ret_req > call_req. At most one request is accepted per edge.
- Call accepted:
  - If depth<DEPTH: go to PUSH. Next cycle, stack_call=1, pc_load=1, pc_next=call_target, req_ack=1; depth+1 on exiting PUSH.
  - If depth=DEPTH: no push, no pc_load. req_ack=1 for one cycle, overflow set. Stay IDLE.
- Interrupt accepted:
  - As call, but pc_next=ISR_ADDR and irq_ack=1 instead of req_ack; in_isr set on exiting PUSH.
  - At depth=DEPTH: overflow set, irq_ack pulses, in_isr still set, no PC change.
- Ret/reti accepted:
  - If depth>0: go to POP. Next cycle, stack_return=1, pc_load=1, pc_next=rts_adr sampled that cycle, req_ack=1; depth-1 on exiting POP. Reti also clears in_isr.
  - If depth=0: underflow set, req_ack pulses, no pop, no pc_load. Reti still clears in_isr.
- Reti with in_isr=0 behaves exactly as ret.
- PUSH and POP always go to SETTLE for one cycle, then IDLE. SETTLE lets the stack's registered top output reflect the new pointer. Minimum spacing between accepted requests is 3 cycles.
- Requests present while busy=1 are not sampled. Requesters hold them until acknowledged.
- Strobes (stack_call, stack_return, pc_load, req_ack, irq_ack) are exactly one cycle wide and never asserted together, except pc_load paired with its stack strobe and ack.
- An irq arriving while in_isr=1 is held off until RETI completes. No nesting.
- Reset mid-PUSH/POP aborts immediately; any partial stack update is the stack's concern.
- depth saturates within 0..DEPTH and never wraps.

Test Plan:
- Reset, then call_req with call_target=12'h123 at pc_in=12'h010 -> one cycle later stack_call=1, pc_load=1, pc_next=12'h123, req_ack=1; depth=1; busy high 2 cycles.
- Call, then ret after busy clears -> POP cycle: stack_return=1, pc_load=1, pc_next=rts_adr (=12'h010 from stack model); depth=0.
- 8 calls then a 9th call -> 9th gives req_ack only, no stack_call, overflow=1 (sticky), depth=8.
- ret_req at depth=0 -> req_ack pulse, no stack_return, underflow=1; reti at depth=0 also clears in_isr.
- irq and call_req asserted on the same edge -> irq wins: pc_next=12'h004, irq_ack=1, in_isr=1; call is accepted 3 cycles later. A second irq is ignored until reti completes, after which in_isr=0.
- Assert reset_n=0 during POP -> all outputs 0 asynchronously; after release, state is IDLE with depth=0.

Source files
------------

// File: rtl/subroutine_ctrl.sv
// Sequencing controller for the subroutine return-address stack.
// Arbitrates call / ret / reti / interrupt entry, drives the stack's one-cycle
// push/pop strobes, tracks stack depth and supplies the PC unit with loads.
module subroutine_ctrl #(
  parameter int                DEPTH    = 8,
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] ISR_ADDR = ADDR_W'('h004)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              call_req,
  input  logic              ret_req,
  input  logic              reti_req,
  input  logic              irq,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [ADDR_W-1:0] call_target,
  input  logic [ADDR_W-1:0] rts_adr,
  output logic              stack_call,
  output logic              stack_return,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_next,
  output logic              req_ack,
  output logic              irq_ack,
  output logic              busy,
  output logic              in_isr,
  output logic [3:0]        depth,
  output logic              overflow,
  output logic              underflow
);

  typedef enum logic [1:0] {IDLE, PUSH, POP, SETTLE} state_t;

  localparam logic [3:0] FULL = 4'(DEPTH);

  state_t            state, state_nx;
  logic              stack_call_nx, stack_return_nx, pc_load_nx;
  logic              req_ack_nx, irq_ack_nx, in_isr_nx;
  logic              overflow_nx, underflow_nx;
  logic [ADDR_W-1:0] pc_next_nx;
  logic [3:0]        depth_nx;
  logic              op_irq, op_irq_nx;
  logic              op_reti, op_reti_nx;

  // The return address is written into the stack directly from pc_in.
  logic unused_pc;
  assign unused_pc = ^pc_in;

  // Arbitration, next state and next values of every registered output.
  always_comb begin
    state_nx        = state;
    stack_call_nx   = 1'b0;
    stack_return_nx = 1'b0;
    pc_load_nx      = 1'b0;
    req_ack_nx      = 1'b0;
    irq_ack_nx      = 1'b0;
    pc_next_nx      = pc_next;
    depth_nx        = depth;
    in_isr_nx       = in_isr;
    overflow_nx     = overflow;
    underflow_nx    = underflow;
    op_irq_nx       = op_irq;
    op_reti_nx      = op_reti;
    case (state)
      IDLE: begin
        // An overflow/underflow ack leaves us in IDLE while the requester
        // still holds its request for this cycle; skip sampling so the same
        // request is not accepted twice.
        if (!(req_ack || irq_ack)) begin
          if (irq && !in_isr) begin
            irq_ack_nx = 1'b1;
            if (depth < FULL) begin
              state_nx      = PUSH;
              stack_call_nx = 1'b1;
              pc_load_nx    = 1'b1;
              pc_next_nx    = ISR_ADDR;
              op_irq_nx     = 1'b1;
            end else begin
              overflow_nx = 1'b1;
              in_isr_nx   = 1'b1;
            end
          end else if (reti_req || ret_req) begin
            req_ack_nx = 1'b1;
            if (depth != '0) begin
              state_nx        = POP;
              stack_return_nx = 1'b1;
              pc_load_nx      = 1'b1;
              pc_next_nx      = rts_adr;
              op_reti_nx      = reti_req;
            end else begin
              underflow_nx = 1'b1;
              if (reti_req) in_isr_nx = 1'b0;
            end
          end else if (call_req) begin
            req_ack_nx = 1'b1;
            if (depth < FULL) begin
              state_nx      = PUSH;
              stack_call_nx = 1'b1;
              pc_load_nx    = 1'b1;
              pc_next_nx    = call_target;
              op_irq_nx     = 1'b0;
            end else begin
              overflow_nx = 1'b1;
            end
          end
        end
      end
      PUSH: begin
        state_nx = SETTLE;
        if (depth < FULL) depth_nx = depth + 4'd1;
        if (op_irq) in_isr_nx = 1'b1;
      end
      POP: begin
        state_nx = SETTLE;
        if (depth != '0) depth_nx = depth - 4'd1;
        if (op_reti) in_isr_nx = 1'b0;
      end
      SETTLE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      stack_call   <= 1'b0;
      stack_return <= 1'b0;
      pc_load      <= 1'b0;
      req_ack      <= 1'b0;
      irq_ack      <= 1'b0;
      pc_next      <= '0;
      busy         <= 1'b0;
      in_isr       <= 1'b0;
      depth        <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      op_irq       <= 1'b0;
      op_reti      <= 1'b0;
    end else begin
      state        <= state_nx;
      stack_call   <= stack_call_nx;
      stack_return <= stack_return_nx;
      pc_load      <= pc_load_nx;
      req_ack      <= req_ack_nx;
      irq_ack      <= irq_ack_nx;
      pc_next      <= pc_next_nx;
      busy         <= (state_nx != IDLE);
      in_isr       <= in_isr_nx;
      depth        <= depth_nx;
      overflow     <= overflow_nx;
      underflow    <= underflow_nx;
      op_irq       <= op_irq_nx;
      op_reti      <= op_reti_nx;
    end
  end

endmodule

// File: tb/tb_subroutine_ctrl.sv
// Self-checking bench for subroutine_ctrl: directed steps plus random
// request traffic, checked against a transaction-level model.
module tb_subroutine_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        call_req = 1'b0, ret_req = 1'b0, reti_req = 1'b0, irq = 1'b0;
  logic [11:0] pc_in = '0, call_target = '0, rts_adr;
  logic        stack_call, stack_return, pc_load, req_ack, irq_ack;
  logic        busy, in_isr, overflow, underflow;
  logic [11:0] pc_next;
  logic [3:0]  depth;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_ack = 0;

  // Transaction-level model state
  int          m_depth;
  bit          m_isr, m_ovf, m_unf;
  logic [11:0] m_stack[$];

  // Environment: the return-address stack the controller drives
  logic [11:0] estk[8];
  int          eptr;

  subroutine_ctrl #(.DEPTH(8), .ADDR_W(12), .ISR_ADDR(12'h004)) dut (
    .clock(clock), .reset_n(reset_n),
    .call_req(call_req), .ret_req(ret_req), .reti_req(reti_req), .irq(irq),
    .pc_in(pc_in), .call_target(call_target), .rts_adr(rts_adr),
    .stack_call(stack_call), .stack_return(stack_return), .pc_load(pc_load),
    .pc_next(pc_next), .req_ack(req_ack), .irq_ack(irq_ack), .busy(busy),
    .in_isr(in_isr), .depth(depth), .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Registered-top stack: push pc_in on stack_call, pop on stack_return.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      eptr    <= 0;
      rts_adr <= '0;
    end else if (stack_call && eptr < 8) begin
      estk[eptr] <= pc_in;
      eptr       <= eptr + 1;
      rts_adr    <= pc_in;
    end else if (stack_return && eptr > 0) begin
      eptr    <= eptr - 1;
      rts_adr <= (eptr > 1) ? estk[eptr-2] : 12'h000;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    m_depth = 0;
    m_isr   = 0;
    m_ovf   = 0;
    m_unf   = 0;
    m_stack.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_flags"}, {23'd0, stack_call, stack_return, pc_load, req_ack, irq_ack,
                          busy, in_isr, overflow, underflow}, 0);
    chk({tag, "_pc"}, pc_next, 0);
    chk({tag, "_depth"}, depth, 0);
  endtask

  // Present a set of requests, predict the winner and outcome, check the ack
  // cycle, the cycle after it, and the settled state.
  task automatic run_op(input bit c, input bit r, input bit ri, input bit i,
                        input logic [11:0] pc, input logic [11:0] tgt);
    int          w;
    bit          push, pop, got;
    logic [11:0] epc;
    w = 0;
    if (i && !m_isr) w = 1;
    else if (ri)     w = 2;
    else if (r)      w = 3;
    else if (c)      w = 4;
    push = (w == 1 || w == 4) && m_depth < 8;
    pop  = (w == 2 || w == 3) && m_depth > 0;
    epc  = (w == 1) ? 12'h004 : (w == 4) ? tgt : (pop ? m_stack[$] : 12'h000);

    @(negedge clock);
    pc_in = pc; call_target = tgt;
    call_req = c; ret_req = r; reti_req = ri; irq = i;
    got = 0;
    for (int k = 0; k < 12; k++) begin
      if (req_ack || irq_ack) begin
        got = 1;
        break;
      end
      @(negedge clock);
    end
    chk("ack_seen", 32'(got), 1);
    last_ack = cyc;
    chk("req_ack", req_ack, (w >= 2) ? 1 : 0);
    chk("irq_ack", irq_ack, (w == 1) ? 1 : 0);
    chk("stack_call", stack_call, push ? 1 : 0);
    chk("stack_return", stack_return, pop ? 1 : 0);
    chk("pc_load", pc_load, (push || pop) ? 1 : 0);
    if (push || pop) chk("pc_next", pc_next, epc);
    chk("busy_op", busy, (push || pop) ? 1 : 0);

    case (w)
      1: irq = 0;
      2: reti_req = 0;
      3: ret_req = 0;
      default: call_req = 0;
    endcase
    case (w)
      1: begin
        if (push) begin m_stack.push_back(pc); m_depth++; end
        else m_ovf = 1;
        m_isr = 1;
      end
      2, 3: begin
        if (pop) begin void'(m_stack.pop_back()); m_depth--; end
        else m_unf = 1;
        if (w == 2) m_isr = 0;
      end
      default: begin
        if (push) begin m_stack.push_back(pc); m_depth++; end
        else m_ovf = 1;
      end
    endcase

    @(negedge clock);
    chk("strobes_clear", {27'd0, stack_call, stack_return, pc_load, req_ack, irq_ack}, 0);
    chk("busy_settle", busy, (push || pop) ? 1 : 0);
    for (int k = 0; k < 6 && busy; k++) @(negedge clock);
    chk("busy_clear", busy, 0);
    chk("depth", depth, m_depth);
    chk("in_isr", in_isr, m_isr);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_unf);
  endtask

  initial begin
    int  a0;
    bit  seen;
    int  kind;

    // Reset state
    #2;
    chk_zero("reset");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1;
    reset_model();

    // Basic call then return
    run_op(1, 0, 0, 0, 12'h010, 12'h123);
    run_op(0, 1, 0, 0, 12'h000, 12'h000);

    // Fill to DEPTH, then overflow via call and via interrupt entry
    for (int n = 0; n < 9; n++) run_op(1, 0, 0, 0, 12'($urandom), 12'($urandom));
    run_op(0, 0, 0, 1, 12'($urandom), 12'h000);

    // Drain, then underflow via ret and via reti (which also leaves the ISR)
    for (int n = 0; n < 9; n++) run_op(0, 1, 0, 0, 12'h000, 12'h000);
    run_op(0, 0, 1, 0, 12'h000, 12'h000);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 3));
      if (kind == 3 && m_isr) kind = 0;
      case (kind)
        0: run_op(1, 0, 0, 0, 12'($urandom), 12'($urandom));
        1: run_op(0, 1, 0, 0, 12'($urandom), 12'($urandom));
        2: run_op(0, 0, 1, 0, 12'($urandom), 12'($urandom));
        default: run_op(0, 0, 0, 1, 12'($urandom), 12'($urandom));
      endcase
    end

    // Bring back to a shallow, non-ISR state
    if (m_isr) run_op(0, 0, 1, 0, 12'h000, 12'h000);
    while (m_depth > 2) run_op(0, 1, 0, 0, 12'h000, 12'h000);

    // irq and call on the same edge: irq wins, held call follows 3 cycles on
    run_op(1, 0, 0, 1, 12'h2a0, 12'h3c5);
    a0 = last_ack;
    run_op(1, 0, 0, 0, 12'h2a0, 12'h3c5);
    chk("call_spacing", 32'(last_ack - a0), 3);

    // A second irq is held off while in the ISR
    @(negedge clock);
    irq = 1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (irq_ack || busy) seen = 1;
    end
    chk("irq_held_off", 32'(seen), 0);
    // reti wins over the held irq, then the irq is taken once in_isr drops
    run_op(0, 0, 1, 1, 12'h000, 12'h000);
    run_op(0, 0, 0, 1, 12'h155, 12'h000);
    run_op(0, 0, 1, 0, 12'h000, 12'h000);

    // Asynchronous reset in the middle of a POP
    @(negedge clock);
    ret_req = 1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (stack_return) begin
        seen = 1;
        break;
      end
    end
    chk("pop_seen", 32'(seen), 1);
    #1 reset_n = 0;
    #1 chk_zero("reset_async");
    ret_req = 0;
    @(negedge clock);
    reset_n = 1;
    reset_model();
    @(negedge clock);
    chk_zero("post_reset");
    run_op(1, 0, 0, 0, 12'h077, 12'h456);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
